fp_mul_booth_seq: RTL and testbench
===================================

FP_MUL_BOOTH_SEQ -- requirements
Module: fp_mul_booth_seq

Interface
REQ-001 SHALL have parameter MAN_W, default 24, meaning significand width including the hidden bit; only 24 is supported.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair present.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have ports frc_X and frc_Y, input, 23 bits each: fraction fields.
REQ-007 SHALL have ports x_sub and y_sub, input, 1 bit each: exponent field is zero, so the hidden bit is 0.
REQ-008 SHALL have port out_valid, output, 1 bit: product available.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream normalizer accepts the product.
REQ-010 SHALL have port frc_Z_full, output, 48 bits: unsigned significand product, fed to the normalizer.
REQ-011 SHALL have port norm_n, output, 1 bit: equals frc_Z_full[47].

Function
REQ-012 SHALL form significands A = {~x_sub, frc_X} and B = {~y_sub, frc_Y}, then zero-extend each to 26 bits signed.
REQ-013 SHALL compute A*B with radix-4 Booth recoding of B: 13 digits in {-2,-1,0,+1,+2}, one digit retired per BUSY cycle.
REQ-014 SHALL add each partial product into an accumulator of at least 52 bits, weighted by 4^i; the final frc_Z_full SHALL equal the exact 48-bit unsigned product.
REQ-015 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-016 SHALL transition IDLE->BUSY when in_valid and in_ready are both high; operands are latched on that edge and the digit counter is cleared to 0.
REQ-017 SHALL stay in BUSY for exactly 13 cycles, with counter 0..12; when counter equals 12 the FSM SHALL move BUSY->DONE.
REQ-018 SHALL assert out_valid only in DONE; frc_Z_full and norm_n SHALL be stable while out_valid is high.
REQ-019 SHALL transition DONE->IDLE on out_ready, or DONE->BUSY when out_ready and in_valid are both high.
REQ-020 SHALL set in_ready = (state==IDLE) OR (state==DONE AND out_ready).
REQ-021 SHALL have a latency of 14 cycles from the accept edge to out_valid high.
REQ-022 SHALL support back-to-back operation at one result per 14 cycles.
REQ-023 SHALL ignore in_valid during BUSY; latched operands SHALL be unaffected by input changes after acceptance.
REQ-024 SHALL hold the result indefinitely in DONE while out_ready is low, with no loss or overwrite.
REQ-025 SHALL produce frc_Z_full = 0 when x_sub=1 and frc_X=0, regardless of B.
REQ-026 SHALL never encounter sign loss: the final accumulator is non-negative and bits above 47 are zero.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, force state IDLE, counter 0, accumulator 0, frc_Z_full 0, norm_n 0, out_valid 0, in_ready 0.
REQ-028 SHALL, on reset asserted during BUSY or DONE, abort the operation and drop the pending result; no out_valid SHALL follow.
REQ-029 SHALL have in_ready go high on the first edge after rst_n returns high.

Structure
REQ-030 SHALL place the state enum (IDLE/BUSY/DONE), MAN_W, digit count 13 and product width 48 in the shared FPU package.
REQ-031 SHALL use one sub-module, fp_booth_digit: combinational mapping of 3 multiplier bits to a signed digit and a ±A/±2A partial product.

Verification
REQ-032 SHALL verify: frc_X=0x2DF854, frc_Y=0x490FDB, subs=0 -> after 14 cycles frc_Z_full = 0xADF854*0xC90FDB exactly, with norm_n = bit 47.
REQ-033 SHALL verify: frc_X=frc_Y=0x7FFFFF, subs=0 -> frc_Z_full=0xFFFFFE000001, norm_n=1.
REQ-034 SHALL verify: frc_X=0, frc_Y=0x490FDB, subs=0 -> frc_Z_full=0x6487ED800000, norm_n=0, [45:23]=0x490FDB.
REQ-035 SHALL verify: x_sub=1, frc_X=0, any Y -> frc_Z_full=0.
REQ-036 SHALL verify: out_ready held low 20 cycles in DONE -> result stable and in_ready=0; then out_ready with in_valid high in the same cycle -> next op accepted and its result appears 14 cycles later.
REQ-037 SHALL verify: rst_n low at BUSY counter 6 -> IDLE, all outputs 0, no out_valid; a new op afterwards completes correctly.

Source files
------------

// File: rtl/fp_mul_booth_seq_pkg.sv
// Shared FPU definitions for the sequential Booth significand multiplier.
// Widths, digit count and the control FSM encoding live here.
package fp_mul_booth_seq_pkg;

   localparam int MAN_W  = 24;
   localparam int OP_W   = 26;
   localparam int PP_W   = 27;
   localparam int ACC_W  = 52;
   localparam int PROD_W = 48;
   localparam int DIGITS = 13;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

endpackage

// File: rtl/fp_mul_booth_seq_digit.sv
// Radix-4 Booth recoder: three multiplier bits select a digit in
// {-2,-1,0,+1,+2} and the matching partial product of A.
module fp_booth_digit
   import fp_mul_booth_seq_pkg::*;
(
   input  logic [2:0]      bits,
   input  logic [OP_W-1:0] a,
   output logic [2:0]      digit,
   output logic [PP_W-1:0] pp
);

   logic [PP_W-1:0] a1;
   logic [PP_W-1:0] a2;

   assign a1 = {1'b0, a};
   assign a2 = {a, 1'b0};

   // digit is two's complement; pp is the signed multiple of A
   always_comb begin
      digit = 3'b000;
      pp    = '0;
      unique case (bits)
         3'b001, 3'b010: begin
            digit = 3'b001;
            pp    = a1;
         end
         3'b011: begin
            digit = 3'b010;
            pp    = a2;
         end
         3'b100: begin
            digit = 3'b110;
            pp    = -a2;
         end
         3'b101, 3'b110: begin
            digit = 3'b111;
            pp    = -a1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier, one digit per cycle.
// 13 BUSY cycles per product, result held in DONE until taken.
module fp_mul_booth_seq #(
   parameter int MAN_W = 24
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MAN_W-2:0]   frc_X,
   input  logic [MAN_W-2:0]   frc_Y,
   input  logic               x_sub,
   input  logic               y_sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*MAN_W-1:0] frc_Z_full,
   output logic               norm_n
);

   import fp_mul_booth_seq_pkg::*;

   localparam logic [3:0] LAST = 4'(DIGITS - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic             live_q, live_d;

   logic [OP_W:0]    b_ext;
   logic [2:0]       bits;
   logic [2:0]       digit;
   logic [PP_W-1:0]  pp;
   logic [ACC_W-1:0] addend;
   logic             accept;

   assign b_ext  = {b_q, 1'b0};
   assign bits   = b_ext[{cnt_q, 1'b0} +: 3];
   assign addend = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp} << {cnt_q, 1'b0};

   fp_booth_digit u_digit (
      .bits  (bits),
      .a     (a_q),
      .digit (digit),
      .pp    (pp)
   );

   assign in_ready   = live_q &
                       ((state_q == IDLE) ||
                        ((state_q == DONE) && out_ready));
   assign accept     = in_valid & in_ready;
   assign out_valid  = (state_q == DONE);
   assign frc_Z_full = acc_q[PROD_W-1:0];
   assign norm_n     = acc_q[PROD_W-1];

   // next state: retire one Booth digit per BUSY cycle, load on accept
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      live_d  = 1'b1;
      unique case (state_q)
         IDLE: ;
         BUSY: begin
            if (digit != 3'b000) acc_d = acc_q + addend;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         state_d = BUSY;
         cnt_d   = '0;
         acc_d   = '0;
         a_d     = {2'b00, ~x_sub, frc_X};
         b_d     = {2'b00, ~y_sub, frc_Y};
      end
   end

   // state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         live_q  <= live_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Self-checking bench for fp_mul_booth_seq: directed corner cases,
// backpressure, mid-operation reset and randomized operands.
module tb_fp_mul_booth_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [22:0] frc_X;
   logic [22:0] frc_Y;
   logic        x_sub;
   logic        y_sub;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] frc_Z_full;
   logic        norm_n;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_mul_booth_seq #(.MAN_W(24)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .frc_X      (frc_X),
      .frc_Y      (frc_Y),
      .x_sub      (x_sub),
      .y_sub      (y_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frc_Z_full (frc_Z_full),
      .norm_n     (norm_n)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] ref_mul(input logic [22:0] fx,
                                           input logic [22:0] fy,
                                           input logic xs,
                                           input logic ys);
      longint unsigned a;
      longint unsigned b;
      longint unsigned p;
      a = {40'd0, ~xs, fx};
      b = {40'd0, ~ys, fy};
      p = a * b;
      return p[47:0];
   endfunction

   task automatic scramble();
      frc_X = 23'($urandom);
      frc_Y = 23'($urandom);
      x_sub = 1'($urandom);
      y_sub = 1'($urandom);
   endtask

   task automatic start_op(input logic [22:0] fx, input logic [22:0] fy,
                           input logic xs, input logic ys);
      int n;
      n = 0;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
      frc_X    = fx;
      frc_Y    = fy;
      x_sub    = xs;
      y_sub    = ys;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble();
   endtask

   // accept edge counts as cycle 1, so out_valid is due on cycle 14
   task automatic wait_result(input string tag, input logic [47:0] exp);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         in_valid = 1'($urandom);
         scramble();
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(n + 1), 64'd14);
      chk({tag, "_z"}, 64'(frc_Z_full), 64'(exp));
      chk({tag, "_norm"}, 64'(norm_n), 64'(exp[47]));
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("valid_drop", 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [47:0] e;
      logic [22:0] fx;
      logic [22:0] fy;
      logic        xs;
      logic        ys;
      int          hold;
      int          seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      frc_X     = '0;
      frc_Y     = '0;
      x_sub     = 1'b0;
      y_sub     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_z", 64'(frc_Z_full), 64'd0);
      chk("rst_norm", 64'(norm_n), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      start_op(23'h2DF854, 23'h490FDB, 1'b0, 1'b0);
      e = 48'hADF854 * 48'hC90FDB;
      wait_result("pi", e);
      release_result();

      start_op(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0);
      wait_result("max", 48'hFFFFFE000001);
      release_result();

      start_op(23'h000000, 23'h490FDB, 1'b0, 1'b0);
      wait_result("one", 48'h6487ED800000);
      chk("one_mid", 64'(frc_Z_full[45:23]), 64'h490FDB);
      release_result();

      start_op(23'h000000, 23'h5A5A5A, 1'b1, 1'b0);
      wait_result("zero", 48'h0);
      release_result();

      // backpressure for 20 cycles, then chain a new op in the same cycle
      start_op(23'h123456, 23'h654321, 1'b0, 1'b0);
      e = ref_mul(23'h123456, 23'h654321, 1'b0, 1'b0);
      wait_result("hold", e);
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("hold_z", 64'(frc_Z_full), 64'(e));
         chk("hold_ready", 64'(in_ready), 64'd0);
         chk("hold_valid", 64'(out_valid), 64'd1);
      end
      frc_X     = 23'h0ABCDE;
      frc_Y     = 23'h3FFFFF;
      x_sub     = 1'b0;
      y_sub     = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("chain_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("chain_busy", 64'(out_valid), 64'd0);
      wait_result("chain", ref_mul(23'h0ABCDE, 23'h3FFFFF, 1'b0, 1'b1));
      release_result();

      // reset while the digit counter sits at 6
      start_op(23'h7F00FF, 23'h00FF00, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_ready", 64'(in_ready), 64'd0);
      chk("abort_z", 64'(frc_Z_full), 64'd0);
      chk("abort_norm", 64'(norm_n), 64'd0);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort_no_valid", 64'(seen), 64'd0);
      start_op(23'h2DF854, 23'h490FDB, 1'b0, 1'b0);
      wait_result("post_rst", 48'hADF854 * 48'hC90FDB);
      release_result();

      for (int k = 0; k < 30; k++) begin
         fx   = 23'($urandom);
         fy   = 23'($urandom);
         xs   = ($urandom_range(0, 3) == 0);
         ys   = ($urandom_range(0, 3) == 0);
         if (k % 7 == 0) fx = '0;
         if (k % 5 == 0) fy = 23'h7FFFFF;
         hold = $urandom_range(0, 3);
         start_op(fx, fy, xs, ys);
         e = ref_mul(fx, fy, xs, ys);
         wait_result("rand", e);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("rand_hold", 64'(frc_Z_full), 64'(e));
         end
         release_result();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
